// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg
// Shared types and constants for the register-file writeback path.
//   XLEN        : datapath width of the integer register file
//   REG_ADDR_W  : register index width
//   wb_entry_t  : one buffered writeback (destination + value)
//   gnt_e       : which source owns the register-file write port this cycle
// ---------------------------------------------------------------------------
package pipeline_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_PIPE = 2'd1,
      GNT_FIFO = 2'd2
   } gnt_e;

endpackage : pipeline_pkg

// File: rtl/wb_result_fifo.sv
// ---------------------------------------------------------------------------
// wb_result_fifo
// Synchronous FIFO of wb_entry_t holding MDU results until the register-file
// write port is free. Head entry is visible combinationally on dout.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (pointers/count only)
//   push, din    : write an entry (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   dout         : current head entry
//   full, empty  : occupancy flags derived from the registered count
//   count        : registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module wb_result_fifo
   import pipeline_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  wb_entry_t                din,
   input  logic                     pop,
   output wb_entry_t                dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t          mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   cnt_q;
   logic               do_push;
   logic               do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[rd_ptr];
   assign count   = cnt_q;

   // Storage carries no reset: stale entries are unreachable once the
   // pointers and count are cleared.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers are exactly log2(DEPTH) bits so they wrap on their own; the
   // separate count tells full apart from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule : wb_result_fifo

// File: rtl/pipeline_wb_arbiter.sv
// ---------------------------------------------------------------------------
// pipeline_wb_arbiter
// Owns the single register-file write port and shares it between the
// in-order WB stage (priority) and out-of-band MDU results, which wait in a
// small FIFO. If a non-empty FIFO loses arbitration STARVE_MAX edges in a
// row, the WB stage is stalled for one cycle so the head entry drains.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   pipe_valid/we/rd/data: retiring WB-stage instruction
//   pipe_stall          : WB stage must hold; pipe_* not consumed
//   mdu_valid/rd/data   : MDU result offer
//   mdu_ready           : FIFO has room (registered state only)
//   rf_we/waddr/wdata   : registered register-file write port
//   pend_count          : registered FIFO occupancy
//
// Optional feature (macro WB_ARB_PERF_EN):
//   perf_stall_cnt      : edges on which pipe_stall was high
//   perf_mdu_wr_cnt     : edges on which the FIFO head was written
// ---------------------------------------------------------------------------
module pipeline_wb_arbiter
   import pipeline_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     pipe_valid,
   input  logic                     pipe_we,
   input  logic [REG_ADDR_W-1:0]    pipe_rd,
   input  logic [XLEN-1:0]          pipe_data,
   output logic                     pipe_stall,
   input  logic                     mdu_valid,
   output logic                     mdu_ready,
   input  logic [REG_ADDR_W-1:0]    mdu_rd,
   input  logic [XLEN-1:0]          mdu_data,
   output logic                     rf_we,
   output logic [REG_ADDR_W-1:0]    rf_waddr,
   output logic [XLEN-1:0]          rf_wdata,
`ifdef WB_ARB_PERF_EN
   output logic [31:0]              perf_stall_cnt,
   output logic [31:0]              perf_mdu_wr_cnt,
`endif
   output logic [$clog2(DEPTH):0]   pend_count
);

   localparam logic [7:0] STARVE_LAST = 8'(STARVE_MAX - 1);

   wb_entry_t  fifo_din;
   wb_entry_t  fifo_head;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_push;
   logic       fifo_pop;
   gnt_e       gnt;
   logic [7:0] starve_cnt;
   logic       force_q;

   // Results for x0 are accepted (handshake completes) but never stored.
   assign mdu_ready = ~fifo_full;
   assign fifo_push = mdu_valid & mdu_ready & (mdu_rd != '0);
   assign fifo_din  = '{rd: mdu_rd, data: mdu_data};
   assign fifo_pop  = (gnt == GNT_FIFO);

   wb_result_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (pend_count)
   );

   // Stall comes only from registered state so it never loops back through
   // the WB stage's own valid.
   always_comb begin
      gnt        = GNT_NONE;
      pipe_stall = 1'b0;
      if (force_q && !fifo_empty) begin
         gnt        = GNT_FIFO;
         pipe_stall = 1'b1;
      end else if (pipe_valid) begin
         gnt = GNT_PIPE;
      end else if (!fifo_empty) begin
         gnt = GNT_FIFO;
      end
   end

   // Starvation tracking: force is a one-cycle pulse, raised on the edge
   // that completes STARVE_MAX consecutive losses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         force_q    <= 1'b0;
      end else begin
         force_q <= 1'b0;
         if ((gnt == GNT_PIPE) && !fifo_empty) begin
            if (starve_cnt == STARVE_LAST) begin
               starve_cnt <= '0;
               force_q    <= 1'b1;
            end else begin
               starve_cnt <= starve_cnt + 8'd1;
            end
         end else begin
            starve_cnt <= '0;
         end
      end
   end

   // Write port register: address/data hold when nothing is granted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         case (gnt)
            GNT_PIPE: begin
               rf_we    <= pipe_we & (pipe_rd != '0);
               rf_waddr <= pipe_rd;
               rf_wdata <= pipe_data;
            end
            GNT_FIFO: begin
               rf_we    <= 1'b1;
               rf_waddr <= fifo_head.rd;
               rf_wdata <= fifo_head.data;
            end
            default: begin
               rf_we    <= 1'b0;
            end
         endcase
      end
   end

`ifdef WB_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt  <= '0;
         perf_mdu_wr_cnt <= '0;
      end else begin
         if (pipe_stall)        perf_stall_cnt  <= perf_stall_cnt + 32'd1;
         if (gnt == GNT_FIFO)   perf_mdu_wr_cnt <= perf_mdu_wr_cnt + 32'd1;
      end
   end
`endif

endmodule : pipeline_wb_arbiter

// File: doc/pipeline_wb_arbiter.md
Name: pipeline_wb_arbiter

Overview:
- Owns the single register-file write port.
- Shares it between the in-order pipeline writeback stage (already-selected wb_data) and the long-latency multiply/divide unit (MDU), whose results return out of band.
- The pipeline has priority. MDU results are buffered in a small FIFO. A starvation counter forces a one-cycle pipeline stall so buffered results drain.
- Sits between the WB mux and the register file.

Parameters:
- DEPTH, 4, MDU result FIFO entries; power of 2, 2..16.
- STARVE_MAX, 8, consecutive cycles a non-empty FIFO may lose arbitration before a forced stall; 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- pipe_valid  input  1  WB stage holds a retiring instruction this cycle
- pipe_we  input  1  instruction writes a register
- pipe_rd  input  5  destination register
- pipe_data  input  32  writeback value
- pipe_stall  output  1  WB stage must hold; pipe_* not consumed this cycle
- mdu_valid  input  1  MDU offers a result
- mdu_ready  output  1  FIFO can accept
- mdu_rd  input  5  MDU destination register
- mdu_data  input  32  MDU result
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  5  write address (registered)
- rf_wdata  output  32  write data (registered)
- pend_count  output  $clog2(DEPTH)+1  FIFO occupancy (registered)

Behaviour:
- Reset (async, rst_n low):
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, pend_count=0, starve counter=0, force flag=0.
  - pipe_stall=0, mdu_ready=1 once reset releases.
  - Reset mid-operation discards all buffered results.
- Enqueue: mdu_ready = (pend_count != DEPTH), from registered state only. An MDU result is accepted on a rising edge with mdu_valid & mdu_ready. mdu_rd=0 is accepted but not stored.
- Grant, evaluated each cycle:
  - force=1 and FIFO non-empty: grant FIFO head, pipe_stall=1.
  - else pipe_valid: grant pipe, pipe_stall=0.
  - else FIFO non-empty: grant FIFO head.
  - else no grant.
- pipe_stall is combinational from the registered force flag and registered occupancy only; it never depends on pipe_valid.
- Write: the granted source drives rf_* at the next edge (one-cycle latency). rf_we=1 only if:
  - pipe grant with pipe_we=1 and pipe_rd!=0, or
  - FIFO grant (always).
- A pipe grant with pipe_we=0 or rd=0 is consumed with rf_we=0.
- Pop: the FIFO head pops on the edge where it is granted.
- Push and pop may occur on the same edge. Count is unchanged; no data loss when full, because mdu_ready was already low.
- Starvation:
  - The counter increments on each edge where the FIFO is non-empty and pipe is granted.
  - It clears on any FIFO grant or when the FIFO is empty.
  - When the counter reaches STARVE_MAX, force is set for exactly the next cycle, then cleared; the counter resets.
  - force never persists more than one cycle.
- Ordering: FIFO drains strictly in arrival order. Issue logic scoreboards MDU destinations, so no WAW conflict between pipe and buffered entries is checked here.
- Wrap-around: read/write pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked separately to distinguish full from empty.

Optional Feature:
- Macro WB_ARB_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] (edges with pipe_stall=1) and perf_mdu_wr_cnt[31:0] (FIFO grants). Both reset to 0, wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - XLEN=32, REG_ADDR_W=5.
  - Typedef wb_entry_t {rd[4:0], data[31:0]}.
  - Grant encoding enum {GNT_NONE, GNT_PIPE, GNT_FIFO}.
- One sub-module, wb_result_fifo: synchronous FIFO of wb_entry_t, DEPTH parameter, push/pop/full/empty/count.
- The arbiter holds grant, starvation and output registers.

Test Plan:
- Reset then pipe_valid=1, we=1, rd=5, data=0xDEADBEEF, no MDU → next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; pipe_stall=0.
- MDU result rd=7, data=0x12 with pipe idle → enqueued; FIFO grant next cycle; rf_we=1, waddr=7, wdata=0x12 the cycle after; pend_count returns to 0.
- Fill FIFO with 4 MDU results while pipe_valid=1 continuously → mdu_ready=0 at pend_count=4. After 8 losing edges, pipe_stall=1 for one cycle; first-enqueued entry written; mdu_ready=1 again.
- Pipe writes rd=0 and MDU result rd=0 → rf_we never asserts; pend_count stays 0.
- Simultaneous MDU push and FIFO pop at pend_count=2 → pend_count stays 2; output order matches arrival order.
- Assert rst_n=0 with 3 entries pending → rf_we=0 and pend_count=0 immediately (async); no buffered result written after release.
